// File: rtl/seq_match_monitor.sv
// Event monitor behind the serial 1101 detector: lifetime count, per-window count,
// threshold alarm and a single-entry valid/request readout of each completed window.
module seq_match_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             match_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] threshold,
    input  logic             rd_req,
    output logic [CNT_W-1:0] total_count,
    output logic             alarm,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             overflow,
    output logic             miss
);

    // state | meaning
    // IDLE  | monitor disabled, timer and window count held at zero
    // RUN   | window in progress, timer counts 0..len_q-1
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [WIN_W-1:0] timer;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] len_last;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] win_final;
    logic             win_end;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        len_last   = '0;
        win_final  = win_cnt;
        win_end    = 1'b0;

        // A latched length of zero behaves as a one-cycle window
        if (len_q != '0) len_last = len_q - WIN_W'(1);
        if (match_in && (win_cnt != CNT_MAX)) win_final = win_cnt + CNT_W'(1);

        case (state)
            IDLE: if (en) state_next = RUN;
            RUN: begin
                if (!en) state_next = IDLE;
                else if (timer == len_last) win_end = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer       <= '0;
            len_q       <= '0;
            win_cnt     <= '0;
            total_count <= '0;
            overflow    <= 1'b0;
            alarm       <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            miss        <= 1'b0;
        end else begin
            if (match_in) begin
                if (total_count == CNT_MAX) overflow <= 1'b1;
                else                        total_count <= total_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    timer   <= '0;
                    win_cnt <= '0;
                    if (en) len_q <= win_len;
                end
                RUN: begin
                    if (!en || win_end) begin
                        timer   <= '0;
                        win_cnt <= '0;
                        if (win_end) len_q <= win_len;
                    end else begin
                        timer   <= timer + WIN_W'(1);
                        win_cnt <= win_final;
                    end
                end
                default: begin
                    timer   <= '0;
                    win_cnt <= '0;
                end
            endcase

            // A new result and a same-cycle pop count as consumed, not missed
            if (win_end) begin
                rd_data  <= win_final;
                rd_valid <= 1'b1;
                alarm    <= (threshold != '0) && (win_final >= threshold);
                if (rd_valid && !rd_req) miss <= 1'b1;
            end else if (rd_req && rd_valid) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
